exec_unit_mc: RTL and testbench

- Multi-cycle, parametrised execution unit between decode/register-file read and register-file writeback.
- ALU operations complete in one clock with a registered result.
- LOAD/STORE run a request/acknowledge transaction on the DMEM port, wait any number of cycles for the acknowledge, and abort on a configurable timeout.
- Accepts instructions through a valid/ready handshake and signals writeback with rd_valid_o.

---
 rtl/simple_processor_pkg.sv | 34 +++
 rtl/exec_unit_mc_alu.sv | 45 ++++
 rtl/exec_unit_mc.sv | 141 ++++++++++++++
 tb/tb_exec_unit_mc.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_processor_pkg.sv
// Shared types and constants for the simple processor datapath.
package simple_processor_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 16;
  localparam int SHAMT_W    = $clog2(DATA_WIDTH);

  // Encodings 13..15 are unassigned and decode as illegal.
  typedef enum logic [3:0] {
    FN_ADD   = 4'd0,
    FN_SUB   = 4'd1,
    FN_ADDI  = 4'd2,
    FN_AND   = 4'd3,
    FN_OR    = 4'd4,
    FN_XOR   = 4'd5,
    FN_NOT   = 4'd6,
    FN_SLL   = 4'd7,
    FN_SLR   = 4'd8,
    FN_SLLI  = 4'd9,
    FN_SLRI  = 4'd10,
    FN_LOAD  = 4'd11,
    FN_STORE = 4'd12
  } func_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MEM  = 1'b1
  } exec_state_t;

  function automatic logic is_mem_func(input func_t f);
    return (f == FN_LOAD) || (f == FN_STORE);
  endfunction

endpackage

// File: rtl/exec_unit_mc_alu.sv
// Combinational ALU for the multi-cycle execution unit.
// Anything that is not an ALU operation (including LOAD/STORE) raises o_illegal;
// the caller is expected to route memory operations before looking at it.
module exec_alu
  import simple_processor_pkg::*;
#(
  parameter int DATA_WIDTH = simple_processor_pkg::DATA_WIDTH
) (
  input  func_t                 i_func,
  input  logic [DATA_WIDTH-1:0] i_rs1,
  input  logic [DATA_WIDTH-1:0] i_rs2,
  input  logic [DATA_WIDTH-1:0] i_imm_ext,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_illegal
);

  localparam int SH_W = $clog2(DATA_WIDTH);

  logic [SH_W-1:0] w_shamt_reg;
  logic [SH_W-1:0] w_shamt_imm;

  assign w_shamt_reg = i_rs2[SH_W-1:0];
  assign w_shamt_imm = i_imm_ext[SH_W-1:0];

  // Operation select; all arithmetic wraps at DATA_WIDTH, all shifts are logical.
  always_comb begin
    o_result  = '0;
    o_illegal = 1'b0;
    case (i_func)
      FN_ADD:  o_result = i_rs1 + i_rs2;
      FN_SUB:  o_result = i_rs1 + ~i_rs2 + DATA_WIDTH'(1);
      FN_ADDI: o_result = i_rs1 + i_imm_ext;
      FN_AND:  o_result = i_rs1 & i_rs2;
      FN_OR:   o_result = i_rs1 | i_rs2;
      FN_XOR:  o_result = i_rs1 ^ i_rs2;
      FN_NOT:  o_result = ~i_rs1;
      FN_SLL:  o_result = i_rs1 << w_shamt_reg;
      FN_SLR:  o_result = i_rs1 >> w_shamt_reg;
      FN_SLLI: o_result = i_rs1 << w_shamt_imm;
      FN_SLRI: o_result = i_rs1 >> w_shamt_imm;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/exec_unit_mc.sv
// Multi-cycle execution unit: single-cycle registered ALU results, and
// LOAD/STORE as a held req/ack transaction on DMEM with a timeout abort.
module exec_unit_mc
  import simple_processor_pkg::*;
#(
  parameter int DATA_WIDTH     = simple_processor_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH     = simple_processor_pkg::ADDR_WIDTH,
  parameter int IMM_WIDTH      = 6,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT    = 16
) (
  input  logic                      clk_i,
  input  logic                      arst_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  func_t                     func_i,
  input  logic [DATA_WIDTH-1:0]     rs1_data_i,
  input  logic [DATA_WIDTH-1:0]     rs2_data_i,
  input  logic [IMM_WIDTH-1:0]      imm_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  output logic                      dmem_req_o,
  output logic [ADDR_WIDTH-1:0]     dmem_addr_o,
  output logic                      dmem_we_o,
  output logic [DATA_WIDTH-1:0]     dmem_wdata_o,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata_i,
  input  logic                      dmem_ack_i,
  output logic                      rd_valid_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic [DATA_WIDTH-1:0]     rd_data_o,
  output logic                      err_o
);

  // Wide enough to hold MEM_TIMEOUT-1 even when MEM_TIMEOUT is 1.
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  exec_state_t               r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic                      r_we;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic [REG_ADDR_WIDTH-1:0] r_mem_rd;
  logic                      r_rd_valid;
  logic [REG_ADDR_WIDTH-1:0] r_rd_addr;
  logic [DATA_WIDTH-1:0]     r_rd_data;
  logic                      r_err;

  logic [DATA_WIDTH-1:0]     w_imm_ext;
  logic [DATA_WIDTH-1:0]     w_alu_result;
  logic                      w_alu_illegal;
  logic                      w_accept;
  logic                      w_timeout;

  assign w_imm_ext = {{(DATA_WIDTH - IMM_WIDTH){imm_i[IMM_WIDTH-1]}}, imm_i};
  assign w_accept  = valid_i & ready_o;
  assign w_timeout = (r_cnt == CNT_LAST);

  exec_alu #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .i_func    (func_i),
    .i_rs1     (rs1_data_i),
    .i_rs2     (rs2_data_i),
    .i_imm_ext (w_imm_ext),
    .o_result  (w_alu_result),
    .o_illegal (w_alu_illegal)
  );

  // Request is a pure decode of the state register so reset drops it without waiting for an edge.
  assign ready_o      = (r_state == IDLE);
  assign dmem_req_o   = (r_state == MEM);
  assign dmem_addr_o  = r_addr;
  assign dmem_we_o    = r_we;
  assign dmem_wdata_o = r_wdata;
  assign rd_valid_o   = r_rd_valid;
  assign rd_addr_o    = r_rd_addr;
  assign rd_data_o    = r_rd_data;
  assign err_o        = r_err;

  // FSM, timeout counter and output registers; strobes default low every cycle.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_mem_rd   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (is_mem_func(func_i)) begin
              r_state  <= MEM;
              r_cnt    <= '0;
              r_addr   <= ADDR_WIDTH'(rs1_data_i);
              r_we     <= (func_i == FN_STORE);
              r_wdata  <= rs2_data_i;
              r_mem_rd <= rd_addr_i;
            end else if (w_alu_illegal) begin
              r_err <= 1'b1;
            end else begin
              r_rd_valid <= 1'b1;
              r_rd_addr  <= rd_addr_i;
              r_rd_data  <= w_alu_result;
            end
          end
        end
        MEM: begin
          // Ack is checked first so it wins over a coincident timeout.
          if (dmem_ack_i || w_timeout) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            if (dmem_ack_i) begin
              if (!r_we) begin
                r_rd_valid <= 1'b1;
                r_rd_addr  <= r_mem_rd;
                r_rd_data  <= dmem_rdata_i;
              end
            end else begin
              r_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit_mc.sv
// Scoreboard bench for exec_unit_mc: stimulus pushes expected writebacks/errors,
// a negedge monitor pops and compares whenever the DUT strobes an output.
module tb_exec_unit_mc;
  import simple_processor_pkg::*;

  localparam int DW = 32;
  localparam int AW = simple_processor_pkg::ADDR_WIDTH;

  logic          clk_i = 1'b0;
  logic          arst_i;
  logic          valid_i;
  logic          ready_o;
  func_t         func_i;
  logic [DW-1:0] rs1_data_i;
  logic [DW-1:0] rs2_data_i;
  logic [5:0]    imm_i;
  logic [4:0]    rd_addr_i;
  logic          dmem_req_o;
  logic [AW-1:0] dmem_addr_o;
  logic          dmem_we_o;
  logic [DW-1:0] dmem_wdata_o;
  logic [DW-1:0] dmem_rdata_i;
  logic          dmem_ack_i;
  logic          rd_valid_o;
  logic [4:0]    rd_addr_o;
  logic [DW-1:0] rd_data_o;
  logic          err_o;

  exec_unit_mc #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .IMM_WIDTH      (6),
    .REG_ADDR_WIDTH (5),
    .MEM_TIMEOUT    (4)
  ) dut (
    .clk_i        (clk_i),
    .arst_i       (arst_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .func_i       (func_i),
    .rs1_data_i   (rs1_data_i),
    .rs2_data_i   (rs2_data_i),
    .imm_i        (imm_i),
    .rd_addr_i    (rd_addr_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_rdata_i (dmem_rdata_i),
    .dmem_ack_i   (dmem_ack_i),
    .rd_valid_o   (rd_valid_o),
    .rd_addr_o    (rd_addr_o),
    .rd_data_o    (rd_data_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic          is_err;
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_wb(input logic [4:0] rd, input logic [DW-1:0] data);
    q.push_back('{is_err: 1'b0, rd: rd, data: data});
  endtask

  task automatic push_err();
    q.push_back('{is_err: 1'b1, rd: 5'd0, data: '0});
  endtask

  // Drive one instruction for exactly one accepting edge; returns at posedge+1.
  task automatic issue(input func_t f, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [5:0] imm, input logic [4:0] rd);
    int w;
    w = 0;
    while (!ready_o && w < 50) begin
      @(posedge clk_i);
      #1;
      w++;
    end
    chk("issue_ready", {63'd0, ready_o}, 64'd1);
    func_i     = f;
    rs1_data_i = a;
    rs2_data_i = b;
    imm_i      = imm;
    rd_addr_i  = rd;
    valid_i    = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
  endtask

  // Monitor: every strobe must match the oldest expectation, in order.
  initial begin
    forever begin
      @(negedge clk_i);
      if (!arst_i && (rd_valid_o || err_o)) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got rd_valid=%0b err=%0b rd=%0d data=0x%0h, required no output",
                   rd_valid_o, err_o, rd_addr_o, rd_data_o);
        end else begin
          m_e = q.pop_front();
          chk("sb_err", {63'd0, err_o}, {63'd0, m_e.is_err});
          chk("sb_rd_valid", {63'd0, rd_valid_o}, {63'd0, ~m_e.is_err});
          if (!m_e.is_err) begin
            chk("sb_rd_addr", {59'd0, rd_addr_o}, {59'd0, m_e.rd});
            chk("sb_rd_data", {32'd0, rd_data_o}, {32'd0, m_e.data});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_i       = 1'b1;
    valid_i      = 1'b0;
    func_i       = FN_ADD;
    rs1_data_i   = '0;
    rs2_data_i   = '0;
    imm_i        = '0;
    rd_addr_i    = '0;
    dmem_rdata_i = '0;
    dmem_ack_i   = 1'b0;
    #1;
    chk("rst_ready", {63'd0, ready_o}, 64'd1);
    chk("rst_req", {63'd0, dmem_req_o}, 64'd0);
    chk("rst_rd_valid", {63'd0, rd_valid_o}, 64'd0);
    chk("rst_err", {63'd0, err_o}, 64'd0);
    chk("rst_rd_data", {32'd0, rd_data_o}, 64'd0);
    chk("rst_we", {63'd0, dmem_we_o}, 64'd0);
    chk("rst_wdata", {32'd0, dmem_wdata_o}, 64'd0);
    repeat (2) @(posedge clk_i);
    #1;
    arst_i = 1'b0;

    // ALU, back-to-back; each result must be visible right after its accepting edge.
    push_wb(5'd1, 32'd12);
    issue(FN_ADD, 32'd7, 32'd5, 6'd0, 5'd1);
    chk("add_latency", {63'd0, rd_valid_o}, 64'd1);
    push_wb(5'd2, 32'hFFFF_FFFE);
    issue(FN_SUB, 32'd3, 32'd5, 6'd0, 5'd2);
    chk("sub_latency", {63'd0, rd_valid_o}, 64'd1);
    push_wb(5'd3, 32'd8);
    issue(FN_ADDI, 32'd10, 32'd0, 6'b111110, 5'd3);
    push_wb(5'd4, 32'd32);
    issue(FN_SLLI, 32'd1, 32'd0, 6'd5, 5'd4);
    push_wb(5'd5, 32'd2);
    issue(FN_SLL, 32'd1, 32'd33, 6'd0, 5'd5);
    push_wb(5'd6, 32'd1);
    issue(FN_SLRI, 32'h8000_0000, 32'd0, 6'b111111, 5'd6);
    push_wb(5'd7, 32'hFFFF_FFFF);
    issue(FN_NOT, 32'd0, 32'd0, 6'd0, 5'd7);
    push_wb(5'd8, 32'h0F0F_00F0);
    issue(FN_XOR, 32'hFF0F_0F0F, 32'hF000_0FFF, 6'd0, 5'd8);

    // Unassigned encoding.
    push_err();
    issue(func_t'(4'hF), 32'd1, 32'd1, 6'd0, 5'd9);
    chk("illegal_ready", {63'd0, ready_o}, 64'd1);

    // LOAD acked on the third request cycle.
    push_wb(5'd10, 32'hDEAD_BEEF);
    issue(FN_LOAD, 32'h40, 32'd0, 6'd0, 5'd10);
    for (int i = 0; i < 3; i++) begin
      chk("load_req", {63'd0, dmem_req_o}, 64'd1);
      chk("load_addr", {{(64-AW){1'b0}}, dmem_addr_o}, 64'h40);
      chk("load_we", {63'd0, dmem_we_o}, 64'd0);
      chk("load_ready", {63'd0, ready_o}, 64'd0);
      if (i == 2) begin
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'hDEAD_BEEF;
      end
      @(posedge clk_i);
      #1;
    end
    dmem_ack_i = 1'b0;
    chk("load_req_drop", {63'd0, dmem_req_o}, 64'd0);
    chk("load_ready_back", {63'd0, ready_o}, 64'd1);

    // STORE acked in its first request cycle.
    issue(FN_STORE, 32'h80, 32'h1234, 6'd0, 5'd11);
    chk("store_req", {63'd0, dmem_req_o}, 64'd1);
    chk("store_we", {63'd0, dmem_we_o}, 64'd1);
    chk("store_wdata", {32'd0, dmem_wdata_o}, 64'h1234);
    chk("store_addr", {{(64-AW){1'b0}}, dmem_addr_o}, 64'h80);
    dmem_ack_i = 1'b1;
    @(posedge clk_i);
    #1;
    dmem_ack_i = 1'b0;
    chk("store_req_drop", {63'd0, dmem_req_o}, 64'd0);
    chk("store_ready_back", {63'd0, ready_o}, 64'd1);
    chk("store_we_idle", {63'd0, dmem_we_o}, 64'd0);
    chk("store_wdata_idle", {32'd0, dmem_wdata_o}, 64'd0);
    chk("store_no_wb", {63'd0, rd_valid_o}, 64'd0);
    chk("rd_data_hold", {32'd0, rd_data_o}, 64'hDEAD_BEEF);

    // Stray ack while idle must be ignored.
    dmem_ack_i = 1'b1;
    @(posedge clk_i);
    #1;
    dmem_ack_i = 1'b0;
    chk("idle_ack_ignored", {63'd0, rd_valid_o}, 64'd0);

    // LOAD that never gets an ack: four request cycles then an error pulse.
    push_err();
    issue(FN_LOAD, 32'h44, 32'd0, 6'd0, 5'd12);
    for (int i = 0; i < 4; i++) begin
      chk("to_req_held", {63'd0, dmem_req_o}, 64'd1);
      @(posedge clk_i);
      #1;
    end
    chk("to_req_drop", {63'd0, dmem_req_o}, 64'd0);
    chk("to_err", {63'd0, err_o}, 64'd1);
    chk("to_no_wb", {63'd0, rd_valid_o}, 64'd0);
    @(posedge clk_i);
    #1;
    chk("to_err_once", {63'd0, err_o}, 64'd0);
    push_wb(5'd13, 32'd3);
    issue(FN_ADD, 32'd1, 32'd2, 6'd0, 5'd13);
    @(posedge clk_i);
    #1;
    chk("rd_data_hold2", {32'd0, rd_data_o}, 64'd3);

    // Asynchronous reset in the middle of a transaction, then a late ack.
    issue(FN_LOAD, 32'h48, 32'd0, 6'd0, 5'd14);
    @(posedge clk_i);
    #2;
    chk("rst_mem_req_before", {63'd0, dmem_req_o}, 64'd1);
    arst_i = 1'b1;
    #1;
    chk("arst_req", {63'd0, dmem_req_o}, 64'd0);
    chk("arst_ready", {63'd0, ready_o}, 64'd1);
    chk("arst_addr", {{(64-AW){1'b0}}, dmem_addr_o}, 64'd0);
    chk("arst_rd_data", {32'd0, rd_data_o}, 64'd0);
    chk("arst_rd_addr", {59'd0, rd_addr_o}, 64'd0);
    @(posedge clk_i);
    #1;
    arst_i       = 1'b0;
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'h55;
    repeat (2) begin
      @(posedge clk_i);
      #1;
    end
    dmem_ack_i = 1'b0;
    chk("late_ack_no_wb", {63'd0, rd_valid_o}, 64'd0);
    chk("late_ack_ready", {63'd0, ready_o}, 64'd1);

    repeat (3) @(posedge clk_i);
    #1;
    chk("sb_drained", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
